// File: rtl/dds_phase_core.sv
// DDS phase core: step re-timing filter, 32-bit phase accumulator and quarter-wave ROM addressing.
// Build macro DDS_PHASE_OFFSET_EN adds the phase_offset port (default build: no offset).
module dds_phase_core #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W:0]   dac_out,
  output logic              wrap,
  output logic              ftw_update
`ifdef DDS_PHASE_OFFSET_EN
  ,
  input  logic [15:0]       phase_offset
`endif
);

  localparam logic [31:0]     FTW_RST = 32'd171798691;
  localparam logic [DATA_W:0] MID     = {1'b1, {DATA_W{1'b0}}};
  localparam int              PW      = ADDR_W + 2;

  logic [31:0] p_off;

`ifdef DDS_PHASE_OFFSET_EN
  assign p_off = {phase_offset, 16'h0};
`else
  assign p_off = '0;
`endif

  logic [31:0]       s1_q, s1_d;
  logic [31:0]       s2_q, s2_d;
  logic [31:0]       ftw_q, ftw_d;
  logic              ftw_update_q, ftw_update_d;
  logic [31:0]       acc_q, acc_d;
  logic              wrap_p0_q, wrap_p0_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              neg1_q, neg1_d;
  logic              wrap1_q, wrap1_d;
  logic              neg2_q, neg2_d;
  logic              wrap2_q, wrap2_d;
  logic [DATA_W:0]   dac_out_q, dac_out_d;
  logic              wrap_q, wrap_d;

  logic [32:0]       sum;
  logic [PW-1:0]     p_top;
  logic [1:0]        quad;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    // a word must be seen on two consecutive samples before it is adopted
    s1_d         = step;
    s2_d         = s1_q;
    ftw_d        = ftw_q;
    ftw_update_d = 1'b0;
    if (s1_q == s2_q && s2_q != ftw_q) begin
      ftw_d        = s2_q;
      ftw_update_d = 1'b1;
    end

    sum       = {1'b0, acc_q} + {1'b0, ftw_q};
    acc_d     = acc_q;
    wrap_p0_d = 1'b0;
    if (en) begin
      acc_d     = sum[31:0];
      wrap_p0_d = sum[32];
    end

    p_top      = PW'((acc_q + p_off) >> (30 - ADDR_W));
    quad       = p_top[PW-1:ADDR_W];
    idx        = p_top[ADDR_W-1:0];
    rom_addr_d = quad[0] ? ~idx : idx;
    neg1_d     = quad[1];
    wrap1_d    = wrap_p0_q;

    neg2_d  = neg1_q;
    wrap2_d = wrap1_q;

    dac_out_d = neg2_q ? MID - {1'b0, rom_data}
                       : MID + {1'b0, rom_data};
    wrap_d    = wrap2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= FTW_RST;
      s2_q         <= FTW_RST;
      ftw_q        <= FTW_RST;
      ftw_update_q <= 1'b0;
      acc_q        <= '0;
      wrap_p0_q    <= 1'b0;
      rom_addr_q   <= '0;
      neg1_q       <= 1'b0;
      wrap1_q      <= 1'b0;
      neg2_q       <= 1'b0;
      wrap2_q      <= 1'b0;
      dac_out_q    <= MID;
      wrap_q       <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      ftw_q        <= ftw_d;
      ftw_update_q <= ftw_update_d;
      acc_q        <= acc_d;
      wrap_p0_q    <= wrap_p0_d;
      rom_addr_q   <= rom_addr_d;
      neg1_q       <= neg1_d;
      wrap1_q      <= wrap1_d;
      neg2_q       <= neg2_d;
      wrap2_q      <= wrap2_d;
      dac_out_q    <= dac_out_d;
      wrap_q       <= wrap_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign dac_out    = dac_out_q;
  assign wrap       = wrap_q;
  assign ftw_update = ftw_update_q;

endmodule

// File: tb/tb_dds_phase_core.sv
// Testbench for dds_phase_core: cycle trace model of phase, ROM echo model, scenario tasks.
// Honours DDS_PHASE_OFFSET_EN to drive and model phase_offset.
module tb_dds_phase_core;

  localparam logic [31:0] RST_FTW = 32'd171798691;
  localparam int TN = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] step = RST_FTW;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data = '0;
  logic [12:0] dac_out;
  logic        wrap;
  logic        ftw_update;
`ifdef DDS_PHASE_OFFSET_EN
  logic [15:0] phase_offset = '0;
  wire  [31:0] off = {phase_offset, 16'h0};
`else
  wire  [31:0] off = 32'h0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM holding rom_data = rom_addr, one cycle of latency
  always @(posedge clk) rom_data <= {2'b00, rom_addr};

  dds_phase_core dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .step       (step),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .dac_out    (dac_out),
    .wrap       (wrap),
    .ftw_update (ftw_update)
`ifdef DDS_PHASE_OFFSET_EN
    ,
    .phase_offset (phase_offset)
`endif
  );

  // reference: tuning-word state plus a per-edge trace of the decoded phase
  bit [31:0] m_s1 = RST_FTW, m_s2 = RST_FTW, m_ftw = RST_FTW, m_acc = 0;
  bit        m_carry = 0, m_upd = 0;
  bit [31:0] tr_p [TN];
  bit        tr_c [TN];
  bit        tr_r [TN];
  int        n = 0;

  always @(posedge clk) begin
    tr_r[n % TN] <= reset;
    tr_p[n % TN] <= reset ? 32'd0 : m_acc + off;
    tr_c[n % TN] <= reset ? 1'b0 : m_carry;
    n <= n + 1;
    if (reset) begin
      m_s1 <= RST_FTW; m_s2 <= RST_FTW; m_ftw <= RST_FTW;
      m_acc <= 0; m_carry <= 0; m_upd <= 0;
    end else begin
      m_s1 <= step;
      m_s2 <= m_s1;
      if (m_s1 == m_s2 && m_s2 != m_ftw) begin
        m_ftw <= m_s2; m_upd <= 1'b1;
      end else m_upd <= 1'b0;
      if (en) begin
        m_acc   <= m_acc + m_ftw;
        m_carry <= ({32'd0, m_acc} + {32'd0, m_ftw}) > 64'hFFFF_FFFF;
      end else m_carry <= 1'b0;
    end
  end

  function automatic int ix(int k);
    return ((k % TN) + TN) % TN;
  endfunction

  function automatic int addr_of(bit [31:0] p);
    int q   = int'(p[31:30]);
    int idx = int'(p[29:20]);
    return (q % 2 == 1) ? 1023 - idx : idx;
  endfunction

  function automatic int dac_of(bit [31:0] p);
    int mag = addr_of(p);
    return p[31] ? 4096 - mag : 4096 + mag;
  endfunction

  function automatic logic [9:0] e_addr();
    int l = ix(n - 1);
    return tr_r[l] ? 10'd0 : 10'(addr_of(tr_p[l]));
  endfunction

  function automatic logic [12:0] e_dac();
    int l = ix(n - 1);
    return tr_r[l] ? 13'd4096 : 13'(dac_of(tr_p[ix(n - 3)]));
  endfunction

  function automatic logic e_wrap();
    int l = ix(n - 1);
    return tr_r[l] ? 1'b0 : tr_c[ix(n - 3)];
  endfunction

  task automatic test_reset();
    reset = 1; en = 0; step = RST_FTW;
    repeat (3) @(negedge clk);
    checks++;
    if (dac_out !== 13'd4096) begin
      errors++; $display("FAIL reset_dac got %0d exp 4096", dac_out);
    end
    checks++;
    if (rom_addr !== 10'd0) begin
      errors++; $display("FAIL reset_addr got %h exp 000", rom_addr);
    end
    checks++;
    if (wrap !== 1'b0 || ftw_update !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b exp 00", wrap, ftw_update);
    end
    reset = 0; en = 1;
    @(negedge clk);
    checks++;
    if (rom_addr !== 10'd0 || ftw_update !== 1'b0) begin
      errors++; $display("FAIL release1 got %h/%b exp 000/0", rom_addr, ftw_update);
    end
    @(negedge clk);
    checks++;
    if (rom_addr !== 10'd163) begin
      errors++; $display("FAIL first_acc got %h exp 0a3", rom_addr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rom_addr !== e_addr() || dac_out !== e_dac() || wrap !== e_wrap()
          || ftw_update !== m_upd) begin
        errors++;
        $display("FAIL reset_run got %h %0d %b %b exp %h %0d %b %b",
                 rom_addr, dac_out, wrap, ftw_update, e_addr(), e_dac(), e_wrap(), m_upd);
      end
    end
  endtask

  task automatic test_quadrant();
    int nw = 0;
    logic [12:0] dseq [4] = '{13'd4096, 13'd5119, 13'd4096, 13'd3073};
    reset = 1; en = 0; step = 32'h4000_0000;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    en = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if (rom_addr !== ((i % 2 == 1) ? 10'h000 : 10'h3FF)) begin
        errors++; $display("FAIL quad_addr cyc %0d got %h", i, rom_addr);
      end
      if (i >= 3) begin
        checks++;
        if (dac_out !== dseq[(i - 3) % 4] || dac_out !== e_dac()) begin
          errors++;
          $display("FAIL quad_dac cyc %0d got %0d exp %0d", i, dac_out, dseq[(i - 3) % 4]);
        end
      end
      if (i >= 5 && i <= 12 && wrap === 1'b1) nw++;
    end
    checks++;
    if (nw != 2) begin
      errors++; $display("FAIL quad_wrap_count got %0d exp 2", nw);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] b;
    int np = 0;
    do b = $urandom(); while (b == 32'h1234_5678 || b == 0);
    step = b;
    repeat (4) @(negedge clk);
    step = 32'h1234_5678;
    @(negedge clk);
    step = b;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ftw_update === 1'b1) np++;
      checks++;
      if (rom_addr !== e_addr() || dac_out !== e_dac() || wrap !== e_wrap()) begin
        errors++; $display("FAIL glitch_run got %h %0d exp %h %0d",
                           rom_addr, dac_out, e_addr(), e_dac());
      end
    end
    checks++;
    if (np != 0) begin
      errors++; $display("FAIL glitch_reject got %0d pulses exp 0", np);
    end
    step = 32'h1234_5678;
    np = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ftw_update === 1'b1) np++;
      checks++;
      if (ftw_update !== (i == 3)) begin
        errors++; $display("FAIL glitch_load cyc %0d got %b exp %b", i, ftw_update, i == 3);
      end
    end
    checks++;
    if (np != 1) begin
      errors++; $display("FAIL glitch_pulses got %0d exp 1", np);
    end
  endtask

  task automatic test_wrap_period();
    int nw = 0;
    logic pw;
    logic [12:0] d0;
    en = 1; step = 32'h8000_0000;
    repeat (8) @(negedge clk);
    pw = wrap;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) nw++;
      checks++;
      if (wrap !== ~pw || wrap !== e_wrap()) begin
        errors++; $display("FAIL half_wrap cyc %0d got %b exp %b", i, wrap, ~pw);
      end
      pw = wrap;
    end
    checks++;
    if (nw != 5) begin
      errors++; $display("FAIL half_wrap_count got %0d exp 5", nw);
    end
    step = 32'h0;
    repeat (7) @(negedge clk);
    d0 = dac_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (wrap !== 1'b0 || dac_out !== d0 || dac_out !== e_dac()) begin
        errors++; $display("FAIL zero_ftw got %b %0d exp 0 %0d", wrap, dac_out, d0);
      end
    end
  endtask

  task automatic test_enable_reset();
    logic [12:0] d3 = '0;
    step = $urandom() | 32'h0100_0000;
    en = 1;
    repeat (6) @(negedge clk);
    en = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) d3 = dac_out;
      checks++;
      if (dac_out !== e_dac() || wrap !== e_wrap() || rom_addr !== e_addr()
          || (i > 3 && dac_out !== d3) || (i > 3 && wrap !== 1'b0)) begin
        errors++; $display("FAIL en_hold cyc %0d got %0d %b exp %0d 0", i, dac_out, wrap, d3);
      end
    end
    en = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if (dac_out !== 13'd4096 || rom_addr !== 10'd0 || wrap !== 1'b0 || ftw_update !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %0d %h %b %b exp 4096 000 0 0",
                         dac_out, rom_addr, wrap, ftw_update);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 3);
        step = (r == 0) ? 32'h0 : (r == 1) ? 32'h8000_0000 : $urandom();
      end
      en = ($urandom_range(0, 5) != 0);
`ifdef DDS_PHASE_OFFSET_EN
      if ($urandom_range(0, 3) == 0) phase_offset = 16'($urandom());
`endif
      @(negedge clk);
      checks++;
      if (rom_addr !== e_addr() || dac_out !== e_dac() || wrap !== e_wrap()
          || ftw_update !== m_upd) begin
        errors++;
        $display("FAIL random cyc %0d got %h %0d %b %b exp %h %0d %b %b", i,
                 rom_addr, dac_out, wrap, ftw_update, e_addr(), e_dac(), e_wrap(), m_upd);
      end
    end
  endtask

  task automatic test_phase_offset();
    logic [9:0]  xa;
    logic [12:0] xd;
    reset = 1; en = 0; step = 32'h0;
`ifdef DDS_PHASE_OFFSET_EN
    phase_offset = 16'h0;
    xa = 10'h3FF; xd = 13'd5119;
`else
    xa = 10'h000; xd = 13'd4096;
`endif
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
`ifdef DDS_PHASE_OFFSET_EN
    phase_offset = 16'h4000;
`endif
    en = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (rom_addr !== xa || dac_out !== xd) begin
      errors++; $display("FAIL phase_offset got %h %0d exp %h %0d", rom_addr, dac_out, xa, xd);
    end
    checks++;
    if (dac_out !== e_dac() || wrap !== 1'b0) begin
      errors++; $display("FAIL offset_model got %0d %b exp %0d 0", dac_out, wrap, e_dac());
    end
  endtask

  initial begin
    test_reset();
    test_quadrant();
    test_glitch();
    test_wrap_period();
    test_enable_reset();
    test_random();
    test_phase_offset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
